// File: rtl/boruss_rom_arbiter.sv
// Round-robin sharing of one combinational program ROM between fetch (F) and data (D) ports.
// Registered ROM address and read data; flags a HALT opcode returned to the fetch port.
module boruss_rom_arbiter #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] HALT_OPCODE = {DATA_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  f_req,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_gnt,
    output logic                  f_rvalid,
    output logic [DATA_WIDTH-1:0] f_rdata,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  halt_seen,
    input  logic                  halt_clr
);

    logic grant_any;
    logic pick_d;
    logic last_d;
    logic slot_valid;
    logic slot_d;
    logic resp_f;
    logic resp_d;

    // last_d=1 after reset so that F wins the first contested edge
    assign grant_any = f_req | d_req;
    assign pick_d    = d_req & (~f_req | ~last_d);
    assign resp_f    = slot_valid & ~slot_d;
    assign resp_d    = slot_valid & slot_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_gnt      <= 1'b0;
            d_gnt      <= 1'b0;
            rom_addr   <= '0;
            last_d     <= 1'b1;
            slot_valid <= 1'b0;
            slot_d     <= 1'b0;
        end else begin
            f_gnt      <= grant_any & ~pick_d;
            d_gnt      <= pick_d;
            slot_valid <= grant_any;
            slot_d     <= pick_d;
            if (grant_any) begin
                rom_addr <= pick_d ? d_addr : f_addr;
                last_d   <= pick_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            f_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            f_rvalid <= resp_f;
            d_rvalid <= resp_d;
            if (resp_f) f_rdata <= rom_data;
            if (resp_d) d_rdata <= rom_data;
        end
    end

    // A HALT response landing on the same edge as halt_clr keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_seen <= 1'b0;
        end else if (resp_f && rom_data == HALT_OPCODE) begin
            halt_seen <= 1'b1;
        end else if (halt_clr) begin
            halt_seen <= 1'b0;
        end
    end

endmodule

// File: tb/tb_boruss_rom_arbiter.sv
// Directed bench for boruss_rom_arbiter: expected read data queued per port at request time,
// a negedge monitor pops and compares on every rvalid pulse.
module tb_boruss_rom_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       f_req = 1'b0, d_req = 1'b0, halt_clr = 1'b0;
    logic [7:0] f_addr = '0, d_addr = '0;
    logic       f_gnt, d_gnt, f_rvalid, d_rvalid, halt_seen;
    logic [7:0] f_rdata, d_rdata, rom_addr, rom_data;

    int checks = 0;
    int errors = 0;
    logic [7:0] fq[$];
    logic [7:0] dq[$];

    always #5 clk = ~clk;

    // ROM contents: HALT at 8'hFF, otherwise addr ^ 8'hA5
    function automatic logic [7:0] rom_fn(input logic [7:0] a);
        return (a == 8'hFF) ? 8'hFF : (a ^ 8'hA5);
    endfunction
    assign rom_data = rom_fn(rom_addr);

    boruss_rom_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .halt_seen(halt_seen), .halt_clr(halt_clr)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (f_rvalid) begin
                if (fq.size() == 0) check("f_rvalid_unexpected", 8'd1, 8'd0);
                else check("f_rdata", f_rdata, fq.pop_front());
            end
            if (d_rvalid) begin
                if (dq.size() == 0) check("d_rvalid_unexpected", 8'd1, 8'd0);
                else check("d_rdata", d_rdata, dq.pop_front());
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((fq.size() != 0 || dq.size() != 0) && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (fq.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("FAIL drain: pending f=%0d d=%0d expected 0", fq.size(), dq.size());
            fq.delete();
            dq.delete();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        step();
        check("rst_f_gnt", {7'd0, f_gnt}, 8'd0);
        check("rst_d_gnt", {7'd0, d_gnt}, 8'd0);
        check("rst_rvalid", {6'd0, f_rvalid, d_rvalid}, 8'd0);
        check("rst_f_rdata", f_rdata, 8'd0);
        check("rst_d_rdata", d_rdata, 8'd0);
        check("rst_rom_addr", rom_addr, 8'd0);
        check("rst_halt", {7'd0, halt_seen}, 8'd0);
        rst_n = 1'b1;
        step();

        // 1: single F read
        fq.push_back(8'hA0);
        f_req = 1'b1; f_addr = 8'h05;
        step();
        check("t1_f_gnt", {7'd0, f_gnt}, 8'd1);
        check("t1_d_gnt", {7'd0, d_gnt}, 8'd0);
        check("t1_rom_addr", rom_addr, 8'h05);
        f_req = 1'b0;
        step();
        check("t1_f_rvalid", {7'd0, f_rvalid}, 8'd1);
        check("t1_f_gnt_drop", {7'd0, f_gnt}, 8'd0);
        check("t1_d_rvalid", {7'd0, d_rvalid}, 8'd0);
        drain();

        // 2: steady dual requests alternate starting with F
        do_reset();
        f_req = 1'b1; f_addr = 8'h00; d_req = 1'b1; d_addr = 8'h12;
        fq.push_back(8'hA5); dq.push_back(8'hB7);
        fq.push_back(8'hA5); dq.push_back(8'hB7);
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin f_req = 1'b0; d_req = 1'b0; end
            step();
            if (k < 4) begin
                check("t2_f_gnt", {7'd0, f_gnt}, {7'd0, (k % 2 == 0)});
                check("t2_d_gnt", {7'd0, d_gnt}, {7'd0, (k % 2 == 1)});
            end
            check("t2_f_rvalid", {7'd0, f_rvalid}, {7'd0, (k % 2 == 1)});
            check("t2_d_rvalid", {7'd0, d_rvalid}, {7'd0, (k >= 1 && k % 2 == 0)});
        end
        drain();

        // 3: back-to-back F stream, no bubbles
        do_reset();
        for (int k = 0; k < 10; k++) begin
            if (k >= 2) check("t3_f_rvalid", {7'd0, f_rvalid}, 8'd1);
            if (k >= 1 && k <= 8) check("t3_f_gnt", {7'd0, f_gnt}, 8'd1);
            f_req = (k < 8);
            f_addr = 8'(k);
            if (k < 8) fq.push_back(rom_fn(8'(k)));
            step();
        end
        check("t3_f_rvalid_end", {7'd0, f_rvalid}, 8'd0);
        drain();

        // 4: halt_seen set by F only, sticky, set beats clear
        do_reset();
        fq.push_back(8'hFF);
        f_req = 1'b1; f_addr = 8'hFF;
        step();
        check("t4_f_gnt", {7'd0, f_gnt}, 8'd1);
        check("t4_halt_pre", {7'd0, halt_seen}, 8'd0);
        f_req = 1'b0;
        step();
        check("t4_halt_set", {7'd0, halt_seen}, 8'd1);
        step();
        check("t4_halt_sticky", {7'd0, halt_seen}, 8'd1);
        halt_clr = 1'b1;
        step();
        halt_clr = 1'b0;
        check("t4_halt_clr", {7'd0, halt_seen}, 8'd0);
        dq.push_back(8'hFF);
        d_req = 1'b1; d_addr = 8'hFF;
        step();
        check("t4_d_gnt", {7'd0, d_gnt}, 8'd1);
        d_req = 1'b0;
        step();
        check("t4_halt_d", {7'd0, halt_seen}, 8'd0);
        check("t4_f_rdata_kept", f_rdata, 8'hFF);
        fq.push_back(8'hFF);
        f_req = 1'b1; f_addr = 8'hFF;
        step();
        f_req = 1'b0; halt_clr = 1'b1;
        step();
        halt_clr = 1'b0;
        check("t4_halt_set_wins", {7'd0, halt_seen}, 8'd1);
        drain();

        // 5: reset during the grant cycle discards the in-flight read
        f_req = 1'b1; f_addr = 8'h05;
        step();
        check("t5_f_gnt", {7'd0, f_gnt}, 8'd1);
        f_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t5_f_gnt_rst", {7'd0, f_gnt}, 8'd0);
        check("t5_rom_addr_rst", rom_addr, 8'd0);
        check("t5_halt_rst", {7'd0, halt_seen}, 8'd0);
        check("t5_f_rdata_rst", f_rdata, 8'd0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t5_no_rvalid", {6'd0, f_rvalid, d_rvalid}, 8'd0);
        end

        // 6: D address changes while F holds the grant; value at D's grant edge is used
        fq.push_back(8'h85); dq.push_back(8'hA9);
        f_req = 1'b1; f_addr = 8'h20; d_req = 1'b1; d_addr = 8'h03;
        step();
        check("t6_f_gnt", {7'd0, f_gnt}, 8'd1);
        check("t6_d_gnt_lose", {7'd0, d_gnt}, 8'd0);
        f_req = 1'b0; d_addr = 8'h0C;
        step();
        check("t6_d_gnt", {7'd0, d_gnt}, 8'd1);
        check("t6_rom_addr", rom_addr, 8'h0C);
        d_req = 1'b0;
        step();
        check("t6_d_rvalid", {7'd0, d_rvalid}, 8'd1);
        check("t6_f_rdata_kept", f_rdata, 8'h85);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
